// File: rtl/boot_loader_if.sv
// Host load-record stream and core memory/run bus for boot_loader.
// Optional checksum signal is present only under BOOT_LOADER_CHECKSUM_EN.
interface boot_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
);
    logic              inValid;
    logic              inReady;
    logic              inIsData;
    logic [ADDR_W-1:0] inAddr;
    logic [DATA_W-1:0] inWord;
    logic              start;
    logic [CNT_W-1:0]  runCycles;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] instructionAddress;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dataAddress;
    logic              instrWriteEnable;
    logic              dataWriteEnable;
    logic              coreRun;
    logic              done;
    logic [CNT_W-1:0]  loadCount;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    modport slave (
        input  inValid, inIsData, inAddr, inWord, start, runCycles,
`ifdef BOOT_LOADER_CHECKSUM_EN
        output checksum,
`endif
        output inReady, instruction, instructionAddress,
        output data, dataAddress, instrWriteEnable, dataWriteEnable,
        output coreRun, done, loadCount
    );

    modport master (
        output inValid, inIsData, inAddr, inWord, start, runCycles,
`ifdef BOOT_LOADER_CHECKSUM_EN
        input  checksum,
`endif
        input  inReady, instruction, instructionAddress,
        input  data, dataAddress, instrWriteEnable, dataWriteEnable,
        input  coreRun, done, loadCount
    );
endinterface

// File: rtl/boot_loader.sv
// Loads instruction/data records into core memories, then runs the core.
// Define BOOT_LOADER_CHECKSUM_EN to add a running sum of written words.
module boot_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          reset,
    boot_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, RUN, DONE
    } state_t;

    state_t state, state_nx;

    logic              ready;
    logic              is_data;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] iaddr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] daddr_q;
    logic              iwe_q;
    logic              dwe_q;
    logic              run_q;
    logic              done_q;
    logic [CNT_W-1:0]  load_count;
    logic              take_load;
    logic              take_start;

    // ready is a register so it reads 0 in the cycle right after reset
    assign take_load  = (state == IDLE) && ready && bus.inValid;
    assign take_start = (state == IDLE) && ready && bus.start
                        && !bus.inValid;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (take_load)
                    state_nx = SETUP;
                else if (take_start)
                    state_nx = (bus.runCycles == '0) ? DONE : RUN;
            end
            SETUP:  state_nx = STROBE;
            STROBE: state_nx = IDLE;
            RUN:    if (cnt == CNT_W'(1)) state_nx = DONE;
            DONE:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready      <= 1'b0;
            is_data    <= 1'b0;
            cnt        <= '0;
            instr_q    <= '0;
            iaddr_q    <= '0;
            data_q     <= '0;
            daddr_q    <= '0;
            iwe_q      <= 1'b0;
            dwe_q      <= 1'b0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            load_count <= '0;
        end else begin
            ready  <= (state_nx == IDLE);
            iwe_q  <= (state == SETUP) && !is_data;
            dwe_q  <= (state == SETUP) && is_data;
            run_q  <= (state_nx == RUN);
            done_q <= (state_nx == DONE);
            if (take_load) begin
                is_data <= bus.inIsData;
                if (bus.inIsData) begin
                    data_q  <= bus.inWord;
                    daddr_q <= bus.inAddr;
                end else begin
                    instr_q <= bus.inWord;
                    iaddr_q <= bus.inAddr;
                end
            end
            if (take_start)
                cnt <= bus.runCycles;
            else if (state == RUN)
                cnt <= cnt - CNT_W'(1);
            // counted only once the strobe completes without reset
            if (state == STROBE && load_count != '1)
                load_count <= load_count + CNT_W'(1);
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            sum_q  <= '0;
        end else begin
            if (take_load)
                word_q <= bus.inWord;
            if (state == STROBE)
                sum_q <= sum_q + word_q;
        end
    end

    assign bus.checksum = sum_q;
`endif

    assign bus.inReady            = ready;
    assign bus.instruction        = instr_q;
    assign bus.instructionAddress = iaddr_q;
    assign bus.data               = data_q;
    assign bus.dataAddress        = daddr_q;
    assign bus.instrWriteEnable   = iwe_q;
    assign bus.dataWriteEnable    = dwe_q;
    assign bus.coreRun            = run_q;
    assign bus.done               = done_q;
    assign bus.loadCount          = load_count;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: loads, run phase, resets, checksum.
// Inputs change and outputs are sampled on the falling edge.
module tb_boot_loader;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    boot_loader_if #(.DATA_W(32), .ADDR_W(7), .CNT_W(16)) bus ();

    boot_loader #(.DATA_W(32), .ADDR_W(7), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rec(input logic d, input logic [6:0] a,
                       input logic [31:0] w);
        bus.inValid  = 1'b1;
        bus.inIsData = d;
        bus.inAddr   = a;
        bus.inWord   = w;
    endtask

    initial begin
        reset         = 1'b1;
        bus.inValid   = 1'b0;
        bus.inIsData  = 1'b0;
        bus.inAddr    = '0;
        bus.inWord    = '0;
        bus.start     = 1'b0;
        bus.runCycles = '0;
        step();
        step();
        chk("rst_ready", bus.inReady, 0);
        chk("rst_instr", bus.instruction, 0);
        chk("rst_run", bus.coreRun, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cnt", bus.loadCount, 0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        chk("rst_sum", bus.checksum, 0);
`endif
        reset = 1'b0;
        step();
        chk("idle_ready", bus.inReady, 1);

        // single instruction record
        rec(1'b0, 7'd0, 32'h8C010000);
        step();
        bus.inValid = 1'b0;
        chk("t1_instr", bus.instruction, 32'h8C010000);
        chk("t1_iaddr", bus.instructionAddress, 0);
        chk("t1_iwe_setup", bus.instrWriteEnable, 0);
        chk("t1_ready_setup", bus.inReady, 0);
        step();
        chk("t1_iwe_strobe", bus.instrWriteEnable, 1);
        chk("t1_dwe_strobe", bus.dataWriteEnable, 0);
        chk("t1_instr_strobe", bus.instruction, 32'h8C010000);
        step();
        chk("t1_iwe_after", bus.instrWriteEnable, 0);
        chk("t1_ready_after", bus.inReady, 1);
        chk("t1_cnt", bus.loadCount, 1);
        chk("t1_instr_after", bus.instruction, 32'h8C010000);

        // back-to-back records with inValid held high
        rec(1'b1, 7'd0, 32'd12);
        step();
        chk("t2_data", bus.data, 12);
        chk("t2_daddr", bus.dataAddress, 0);
        chk("t2_instr_hold", bus.instruction, 32'h8C010000);
        rec(1'b0, 7'd1, 32'h20420003);
        step();
        chk("t2_dwe", bus.dataWriteEnable, 1);
        chk("t2_iwe", bus.instrWriteEnable, 0);
        chk("t2_not_taken", bus.instruction, 32'h8C010000);
        step();
        chk("t2_dwe_off", bus.dataWriteEnable, 0);
        chk("t2_ready", bus.inReady, 1);
        chk("t2_cnt", bus.loadCount, 2);
        step();
        bus.inValid = 1'b0;
        chk("t2_instr2", bus.instruction, 32'h20420003);
        chk("t2_iaddr2", bus.instructionAddress, 1);
        chk("t2_iwe_setup2", bus.instrWriteEnable, 0);
        step();
        chk("t2_iwe2", bus.instrWriteEnable, 1);
        chk("t2_data_hold", bus.data, 12);
        step();
        chk("t2_cnt2", bus.loadCount, 3);

        // load and start together: load wins, start dropped
        rec(1'b1, 7'd5, 32'hFFFFFFFF);
        bus.start     = 1'b1;
        bus.runCycles = 16'd5;
        step();
        bus.inValid = 1'b0;
        bus.start   = 1'b0;
        chk("t5_run_setup", bus.coreRun, 0);
        chk("t5_data", bus.data, 32'hFFFFFFFF);
        step();
        chk("t5_dwe", bus.dataWriteEnable, 1);
        step();
        chk("t5_ready", bus.inReady, 1);
        chk("t5_cnt", bus.loadCount, 4);
        step();
        chk("t5_no_run", bus.coreRun, 0);
        chk("t5_no_done", bus.done, 0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        chk("t5_sum", bus.checksum, 32'hAC43000E);
`endif

        // run for 5 cycles, loads offered during RUN are ignored
        bus.start     = 1'b1;
        bus.runCycles = 16'd5;
        step();
        bus.start = 1'b0;
        rec(1'b1, 7'd9, 32'h00000055);
        chk("t3_run_c1", bus.coreRun, 1);
        chk("t3_ready_run", bus.inReady, 0);
        for (int i = 2; i <= 5; i++) begin
            step();
            chk($sformatf("t3_run_c%0d", i), bus.coreRun, 1);
            chk($sformatf("t3_done_c%0d", i), bus.done, 0);
        end
        step();
        chk("t3_run_end", bus.coreRun, 0);
        chk("t3_done", bus.done, 1);
        chk("t3_data_kept", bus.data, 32'hFFFFFFFF);
        chk("t3_cnt", bus.loadCount, 4);
        step();
        bus.inValid = 1'b0;
        chk("t3_done_sticky", bus.done, 1);
        chk("t3_ready_done", bus.inReady, 0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("r1_done", bus.done, 0);
        chk("r1_cnt", bus.loadCount, 0);
        chk("r1_data", bus.data, 0);
        step();

        // zero-length run goes straight to done
        bus.start     = 1'b1;
        bus.runCycles = 16'd0;
        step();
        bus.start = 1'b0;
        chk("t4_done", bus.done, 1);
        chk("t4_run", bus.coreRun, 0);
        step();
        chk("t4_done2", bus.done, 1);
        chk("t4_run2", bus.coreRun, 0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // reset in the middle of RUN
        bus.start     = 1'b1;
        bus.runCycles = 16'd10;
        step();
        bus.start = 1'b0;
        chk("t6_run", bus.coreRun, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_run_rst", bus.coreRun, 0);
        chk("t6_done_rst", bus.done, 0);
        chk("t6_ready_rst", bus.inReady, 0);
        step();
        chk("t6_ready", bus.inReady, 1);
        step();
        chk("t6_no_run", bus.coreRun, 0);

        // reset during STROBE drops the record
        rec(1'b0, 7'd2, 32'h00001234);
        step();
        bus.inValid = 1'b0;
        step();
        chk("t7_iwe", bus.instrWriteEnable, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t7_iwe_rst", bus.instrWriteEnable, 0);
        chk("t7_instr_rst", bus.instruction, 0);
        chk("t7_cnt_rst", bus.loadCount, 0);
        step();
        chk("t7_cnt", bus.loadCount, 0);
        chk("t7_ready", bus.inReady, 1);

        // wraparound sum: 0xFFFFFFFF + 2
        rec(1'b0, 7'd3, 32'hFFFFFFFF);
        step();
        bus.inValid = 1'b0;
        step();
        step();
        rec(1'b1, 7'd4, 32'h00000002);
        step();
        bus.inValid = 1'b0;
        step();
        step();
        chk("t8_cnt", bus.loadCount, 2);
        chk("t8_instr", bus.instruction, 32'hFFFFFFFF);
        chk("t8_data", bus.data, 2);
`ifdef BOOT_LOADER_CHECKSUM_EN
        chk("t8_sum", bus.checksum, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
# boot_loader

Sequencer between the host and the MIPS core: accepts a stream of load records (instruction or data words), writes each into the core's instruction or data memory with a setup-then-strobe sequence, then releases the core to run for a programmed number of clock cycles and flags completion. It replaces hand-timed memory preloading. It is parametrised in word width, address width and run-counter width, and drives separate instruction and data write strobes.

## Interface
- DATA_W, 32, instruction/data word width
- ADDR_W, 7, memory word-address width
- CNT_W, 16, width of run-cycle counter and load counter
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- inValid  in  1  load record offered
- inReady  out  1  loader can accept a record this cycle
- inIsData  in  1  0 = instruction record, 1 = data record
- inAddr  in  ADDR_W  target word address
- inWord  in  DATA_W  word to write
- start  in  1  begin run phase (sampled in IDLE only)
- runCycles  in  CNT_W  run length, sampled when start accepted
- instruction  out  DATA_W  instruction word to core
- instructionAddress  out  ADDR_W  instruction address to core
- data  out  DATA_W  data word to core
- dataAddress  out  ADDR_W  data address to core
- instrWriteEnable  out  1  one-cycle instruction-memory write strobe
- dataWriteEnable  out  1  one-cycle data-memory write strobe
- coreRun  out  1  core enable, high during RUN
- done  out  1  sticky completion flag
- loadCount  out  CNT_W  records written since reset (saturating)
- checksum  out  DATA_W  only with BOOT_LOADER_CHECKSUM_EN

## Operation
- States: IDLE, SETUP, STROBE, RUN, DONE. Reset → IDLE; all outputs 0, inReady 0 in the reset cycle, 1 in IDLE afterwards.
- IDLE: inReady=1. inValid=1 accepts a record: instruction/instructionAddress (inIsData=0) or data/dataAddress (inIsData=1) registered; the other bus pair holds its previous value; → SETUP.
- SETUP: inReady=0, strobes 0, buses stable; → STROBE.
- STROBE: exactly one of instrWriteEnable/dataWriteEnable =1 per inIsData; loadCount increments (saturates at all-ones); → IDLE.
- IDLE with start=1 and inValid=0: latch runCycles into down-counter; if runCycles=0 → DONE directly (coreRun never asserted), else → RUN.
- Simultaneous inValid and start in IDLE: the load wins; start is ignored and must be re-asserted.
- RUN: coreRun=1; counter decrements each cycle; after exactly runCycles cycles → DONE. inReady=0, inValid ignored, start ignored.
- DONE: done=1, coreRun=0, inReady=0; stays until reset.
- Reset in any state (including mid-STROBE or RUN) returns to IDLE next edge with all outputs cleared; a record in SETUP/STROBE is dropped and not counted.

## Timing
- Record accepted at edge N: buses valid from N+1, strobe high during cycle N+2 only, inReady back to 1 at N+3. Throughput: one record per 3 cycles.
- Buses stable one full cycle before and during the strobe; unchanged the cycle after.
- start accepted at edge S: coreRun high for cycles S+1 .. S+runCycles; done rises at S+runCycles+1.
- All outputs registered; no combinational input-to-output path except none (inReady from state only).

## Configuration
- BOOT_LOADER_CHECKSUM_EN defined: checksum port present; reset to 0; at each STROBE adds inWord modulo 2^DATA_W (instruction and data records alike); frozen outside STROBE.
- Undefined: checksum port and adder absent; all other behaviour identical.

## Test plan
- Reset then single instruction record (addr 0, 0x8C010000) → instruction=0x8C010000, instructionAddress=0 one cycle before instrWriteEnable pulses for exactly 1 cycle; dataWriteEnable stays 0; loadCount=1.
- Data record (addr 0, 12) then instruction record (addr 1, 0x20420003) back-to-back with inValid held → second accepted 3 cycles after first; data bus keeps 12 during second write; loadCount=2.
- start with runCycles=5 → coreRun high exactly 5 cycles, done rises next cycle and stays; inValid during RUN never accepted.
- start with runCycles=0 → done next cycle, coreRun never high.
- inValid and start asserted same IDLE cycle → record written, state returns to IDLE, no RUN until start re-asserted.
- reset asserted during STROBE and during RUN → next cycle all outputs 0, loadCount unchanged by dropped record; with BOOT_LOADER_CHECKSUM_EN, words 0xFFFFFFFF + 2 → checksum=1.
